ula_dram_responder: RTL and testbench

- Behavioural responder for the ULA's multiplexed DRAM port: 7-bit row/column address, n_RAS, n_CAS, n_WE, 8-bit data.
- Latches row on RAS fall and column on CAS fall, then serves reads and early writes from an internal array.
- Supports page mode, which the ULA uses for bitmap/attribute fetch pairs, and counts RAS-only refresh cycles.
- Flags protocol violations so ULA video/contention timing can be checked end-to-end in simulation.

---
 rtl/ula_dram_responder.sv | 259 +++++++++++++++++++++++++
 tb/tb_ula_dram_responder.sv | 286 ++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ula_dram_responder.sv
// ula_dram_responder
// Behavioural model of the DRAM attached to the ULA's multiplexed memory port.
// Strobes, address and data are registered once on OSC rise. Edges are found by
// comparing that registered copy with the previous one. Every response is
// registered on the OSC edge that closes the cycle in which the edge was seen.
// Read data timing is anchored on the OSC edge that first samples n_CAS low:
// DO/DO_EN update exactly ACCESS_LAT edges after it. DO_EN drops on the edge
// that closes the cycle in which a CAS rise (or an aborting RAS rise) is seen.
// ACCESS_LAT must lie in 1..4 and COL_BITS must equal ROW_BITS.
module ula_dram_responder #(
    parameter int ROW_BITS   = 7,
    parameter int COL_BITS   = 7,
    parameter int DATA_W     = 8,
    parameter int ACCESS_LAT = 2
) (
    input  logic                OSC,
    input  logic                n_RES,
    input  logic                n_RAS,
    input  logic                n_CAS,
    input  logic                n_WE,
    input  logic [ROW_BITS-1:0] A,
    input  logic [DATA_W-1:0]   DI,
    output logic [DATA_W-1:0]   DO,
    output logic                DO_EN,
    output logic [7:0]          REFRESH_CNT,
    output logic                ERR
);

    localparam int         ADDR_W   = ROW_BITS + COL_BITS;
    localparam int         DEPTH    = 1 << ADDR_W;
    // The CAS-fall edge itself is the first of the ACCESS_LAT edges, so the
    // countdown starts one short.
    localparam logic [2:0] LAT_LOAD = 3'(ACCESS_LAT - 1);

    typedef enum logic [1:0] {
        ST_IDLE      = 2'd0,
        ST_RAS_ACT   = 2'd1,
        ST_CAS_ACT   = 2'd2,
        ST_PAGE_WAIT = 2'd3
    } state_t;

    // Sampled inputs and strobe history
    logic                r_ras_q;
    logic                r_ras_prev;
    logic                r_cas_q;
    logic                r_cas_prev;
    logic                r_we_q;
    logic [ROW_BITS-1:0] r_a_q;
    logic [DATA_W-1:0]   r_di_q;

    // Protocol state
    state_t              r_state;
    logic [ROW_BITS-1:0] r_row;
    logic [COL_BITS-1:0] r_col;
    logic                r_cas_seen;
    logic [2:0]          r_lat;
    logic                r_do_en;
    logic [DATA_W-1:0]   r_do;
    logic [7:0]          r_ref;
    logic                r_err;

    // Storage (contents survive reset)
    logic [DATA_W-1:0]   r_mem [0:DEPTH-1];

    // Next-state values
    state_t              w_state_nxt;
    logic [ROW_BITS-1:0] w_row_nxt;
    logic [COL_BITS-1:0] w_col_nxt;
    logic                w_cas_seen_nxt;
    logic [2:0]          w_lat_nxt;
    logic                w_do_en_nxt;
    logic                w_do_load;
    logic [7:0]          w_ref_nxt;
    logic                w_err_nxt;
    logic                w_mem_we;

    // Edge events and addresses
    logic                w_ras_fall;
    logic                w_ras_rise;
    logic                w_cas_fall;
    logic                w_cas_rise;
    logic [ADDR_W-1:0]   w_wr_addr;
    logic [ADDR_W-1:0]   w_rd_addr;

    assign w_ras_fall  = r_ras_prev & ~r_ras_q;
    assign w_ras_rise  = ~r_ras_prev & r_ras_q;
    assign w_cas_fall  = r_cas_prev & ~r_cas_q;
    assign w_cas_rise  = ~r_cas_prev & r_cas_q;

    // Early write goes to the row held for this RAS and the column on the bus now.
    assign w_wr_addr   = {r_row, r_a_q};
    // Read uses the column that is (or is about to be) latched for this access.
    assign w_rd_addr   = {r_row, w_col_nxt};

    assign DO          = r_do;
    assign DO_EN       = r_do_en;
    assign REFRESH_CNT = r_ref;
    assign ERR         = r_err;

    // Register the pins once and keep one cycle of strobe history for edge detection.
    always_ff @(posedge OSC or negedge n_RES) begin
        if (!n_RES) begin
            r_ras_q    <= 1'b1;
            r_ras_prev <= 1'b1;
            r_cas_q    <= 1'b1;
            r_cas_prev <= 1'b1;
            r_we_q     <= 1'b1;
            r_a_q      <= '0;
            r_di_q     <= '0;
        end else begin
            r_ras_q    <= n_RAS;
            r_ras_prev <= r_ras_q;
            r_cas_q    <= n_CAS;
            r_cas_prev <= r_cas_q;
            r_we_q     <= n_WE;
            r_a_q      <= A;
            r_di_q     <= DI;
        end
    end

    // Protocol state register together with the registered outputs.
    always_ff @(posedge OSC or negedge n_RES) begin
        if (!n_RES) begin
            r_state    <= ST_IDLE;
            r_row      <= '0;
            r_col      <= '0;
            r_cas_seen <= 1'b0;
            r_lat      <= 3'd0;
            r_do_en    <= 1'b0;
            r_ref      <= 8'd0;
            r_err      <= 1'b0;
        end else begin
            r_state    <= w_state_nxt;
            r_row      <= w_row_nxt;
            r_col      <= w_col_nxt;
            r_cas_seen <= w_cas_seen_nxt;
            r_lat      <= w_lat_nxt;
            r_do_en    <= w_do_en_nxt;
            r_ref      <= w_ref_nxt;
            r_err      <= w_err_nxt;
        end
    end

    // Read data register: loaded only when an access completes its latency.
    always_ff @(posedge OSC or negedge n_RES) begin
        if (!n_RES) begin
            r_do <= '0;
        end else if (w_do_load) begin
            r_do <= r_mem[w_rd_addr];
        end else begin
            r_do <= r_do;
        end
    end

    // Early-write port into the storage array; no reset so data persists.
    always_ff @(posedge OSC) begin
        if (w_mem_we) begin
            r_mem[w_wr_addr] <= r_di_q;
        end
    end

    // Next-state and output decisions for one sampled cycle.
    always_comb begin
        w_state_nxt    = r_state;
        w_row_nxt      = r_row;
        w_col_nxt      = r_col;
        w_cas_seen_nxt = r_cas_seen;
        w_lat_nxt      = r_lat;
        w_do_en_nxt    = r_do_en;
        w_do_load      = 1'b0;
        w_ref_nxt      = r_ref;
        w_err_nxt      = r_err;
        w_mem_we       = 1'b0;

        case (r_state)
            ST_IDLE: begin
                if (w_ras_fall) begin
                    w_row_nxt   = r_a_q;
                    w_state_nxt = ST_RAS_ACT;
                    if (w_cas_fall) begin
                        // Coincident strobes: row is taken, the column is not.
                        // The cycle is not RAS-only, so it must not count as refresh.
                        w_err_nxt      = 1'b1;
                        w_cas_seen_nxt = 1'b1;
                    end else begin
                        w_cas_seen_nxt = 1'b0;
                    end
                end else if (w_cas_fall) begin
                    // CAS-before-RAS refresh is not modelled.
                    w_err_nxt = 1'b1;
                end else begin
                    w_state_nxt = ST_IDLE;
                end
            end

            ST_RAS_ACT, ST_PAGE_WAIT: begin
                if (w_ras_rise) begin
                    w_state_nxt = ST_IDLE;
                    if ((r_state == ST_RAS_ACT) && !r_cas_seen) begin
                        w_ref_nxt = r_ref + 8'd1;
                    end else begin
                        w_ref_nxt = r_ref;
                    end
                end else if (w_cas_fall) begin
                    w_col_nxt      = r_a_q;
                    w_cas_seen_nxt = 1'b1;
                    w_state_nxt    = ST_CAS_ACT;
                    if (!r_we_q) begin
                        // Early write: committed on this edge, no read data.
                        w_mem_we  = 1'b1;
                        w_lat_nxt = 3'd0;
                    end else if (ACCESS_LAT == 1) begin
                        w_do_load   = 1'b1;
                        w_do_en_nxt = 1'b1;
                        w_lat_nxt   = 3'd0;
                    end else begin
                        w_lat_nxt = LAT_LOAD;
                    end
                end else begin
                    w_state_nxt = r_state;
                end
            end

            ST_CAS_ACT: begin
                if (w_ras_rise) begin
                    w_state_nxt = ST_IDLE;
                    w_do_en_nxt = 1'b0;
                    w_lat_nxt   = 3'd0;
                    if (!r_cas_q) begin
                        // RAS released with CAS still low aborts the access.
                        w_err_nxt = 1'b1;
                    end else begin
                        w_err_nxt = r_err;
                    end
                end else if (w_cas_rise) begin
                    // Ends this column access; a pending read is dropped silently.
                    w_state_nxt = ST_PAGE_WAIT;
                    w_do_en_nxt = 1'b0;
                    w_lat_nxt   = 3'd0;
                end else if (r_lat == 3'd1) begin
                    w_lat_nxt   = 3'd0;
                    w_do_en_nxt = 1'b1;
                    w_do_load   = 1'b1;
                end else if (r_lat != 3'd0) begin
                    w_lat_nxt = r_lat - 3'd1;
                end else begin
                    w_lat_nxt = 3'd0;
                end
            end

            default: begin
                w_state_nxt = ST_IDLE;
                w_do_en_nxt = 1'b0;
                w_lat_nxt   = 3'd0;
            end
        endcase
    end

endmodule

// File: tb/tb_ula_dram_responder.sv
// Directed bench for ula_dram_responder: a vector table for write/read and
// page-mode traffic, then hand-written sequences for the multi-cycle corners.
// Inputs change just after OSC fall; outputs are checked just after OSC fall.
module tb_ula_dram_responder;

    logic       OSC = 1'b0;
    logic       n_RES = 1'b0;
    logic       n_RAS = 1'b1;
    logic       n_CAS = 1'b1;
    logic       n_WE = 1'b1;
    logic [6:0] A = 7'h00;
    logic [7:0] DI = 8'h00;
    logic [7:0] DO;
    logic       DO_EN;
    logic [7:0] REFRESH_CNT;
    logic       ERR;

    int total = 0;
    int bad = 0;

    ula_dram_responder #(
        .ROW_BITS  (7),
        .COL_BITS  (7),
        .DATA_W    (8),
        .ACCESS_LAT(2)
    ) dut (
        .OSC        (OSC),
        .n_RES      (n_RES),
        .n_RAS      (n_RAS),
        .n_CAS      (n_CAS),
        .n_WE       (n_WE),
        .A          (A),
        .DI         (DI),
        .DO         (DO),
        .DO_EN      (DO_EN),
        .REFRESH_CNT(REFRESH_CNT),
        .ERR        (ERR)
    );

    always #5 OSC = ~OSC;

    typedef struct {
        logic       ras;
        logic       cas;
        logic       we;
        logic [6:0] a;
        logic [7:0] di;
        logic       en;
        logic       chk;
        logic [7:0] dov;
    } vec_t;

    vec_t tbl[$];

    function automatic void add(input logic ras, input logic cas, input logic we,
                                input logic [6:0] a, input logic [7:0] di,
                                input logic en, input logic chk, input logic [7:0] dov);
        vec_t v;
        v.ras = ras; v.cas = cas; v.we = we; v.a = a; v.di = di;
        v.en = en; v.chk = chk; v.dov = dov;
        tbl.push_back(v);
    endfunction

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        total++;
        if (act !== exp) begin
            bad++;
            $display("FAIL %s: got %0h want %0h", name, act, exp);
        end
    endtask

    task automatic step(input int n);
        repeat (n) @(negedge OSC);
    endtask

    task automatic apply_reset();
        n_RES = 1'b0;
        n_RAS = 1'b1; n_CAS = 1'b1; n_WE = 1'b1;
        #1;
        check("rst_do", {24'd0, DO}, 32'd0);
        check("rst_en", {31'd0, DO_EN}, 32'd0);
        check("rst_ref", {24'd0, REFRESH_CNT}, 32'd0);
        check("rst_err", {31'd0, ERR}, 32'd0);
        step(2);
        n_RES = 1'b1;
        step(1);
    endtask

    task automatic start_ras(input logic [6:0] row);
        n_RAS = 1'b0; n_CAS = 1'b1; A = row;
        step(2);
    endtask

    task automatic end_ras();
        n_RAS = 1'b1; n_CAS = 1'b1; n_WE = 1'b1;
        step(2);
    endtask

    // Read one column inside an open RAS; checks the exact DO_EN window.
    task automatic do_read(input string name, input logic [6:0] col, input logic [7:0] exp);
        n_CAS = 1'b0; n_WE = 1'b1; A = col;
        step(2);
        check({name, "_early"}, {31'd0, DO_EN}, 32'd0);
        step(1);
        check({name, "_en"}, {31'd0, DO_EN}, 32'd1);
        check({name, "_do"}, {24'd0, DO}, {24'd0, exp});
        n_CAS = 1'b1;
        step(1);
        check({name, "_hold"}, {31'd0, DO_EN}, 32'd1);
        step(1);
        check({name, "_off"}, {31'd0, DO_EN}, 32'd0);
    endtask

    initial begin
        logic seen_en;

        // ras cas we  a      di     en   chk  do
        add(1'b1, 1'b1, 1'b1, 7'h00, 8'h00, 1'b0, 1'b1, 8'h00);
        add(1'b0, 1'b1, 1'b1, 7'h12, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 1'b1, 7'h12, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b0, 7'h34, 8'hA5, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b0, 7'h34, 8'hA5, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 1'b1, 7'h34, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b1, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b1, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b1, 7'h00, 8'h00, 1'b0, 1'b1, 8'h00);
        add(1'b0, 1'b1, 1'b1, 7'h12, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 1'b1, 7'h12, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b1, 7'h34, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b1, 7'h34, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b1, 7'h34, 8'h00, 1'b1, 1'b1, 8'hA5);
        add(1'b0, 1'b0, 1'b1, 7'h34, 8'h00, 1'b1, 1'b1, 8'hA5);
        add(1'b0, 1'b1, 1'b1, 7'h34, 8'h00, 1'b1, 1'b1, 8'hA5);
        add(1'b1, 1'b1, 1'b1, 7'h00, 8'h00, 1'b0, 1'b1, 8'hA5);
        add(1'b1, 1'b1, 1'b1, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b1, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        // page-mode writes at row 5, columns 0 and 1
        add(1'b0, 1'b1, 1'b1, 7'h05, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 1'b1, 7'h05, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b0, 7'h00, 8'h11, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b0, 7'h00, 8'h11, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 1'b1, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b0, 7'h01, 8'h22, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b0, 7'h01, 8'h22, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 1'b1, 7'h01, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b1, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b1, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b1, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        // page-mode reads at row 5, columns 0 then 1
        add(1'b0, 1'b1, 1'b1, 7'h05, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b1, 1'b1, 7'h05, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b1, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b1, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b0, 1'b0, 1'b1, 7'h00, 8'h00, 1'b1, 1'b1, 8'h11);
        add(1'b0, 1'b1, 1'b1, 7'h00, 8'h00, 1'b1, 1'b1, 8'h11);
        add(1'b0, 1'b0, 1'b1, 7'h01, 8'h00, 1'b0, 1'b1, 8'h11);
        add(1'b0, 1'b0, 1'b1, 7'h01, 8'h00, 1'b0, 1'b1, 8'h11);
        add(1'b0, 1'b0, 1'b1, 7'h01, 8'h00, 1'b1, 1'b1, 8'h22);
        add(1'b0, 1'b1, 1'b1, 7'h01, 8'h00, 1'b1, 1'b1, 8'h22);
        add(1'b1, 1'b1, 1'b1, 7'h00, 8'h00, 1'b0, 1'b1, 8'h22);
        add(1'b1, 1'b1, 1'b1, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00);
        add(1'b1, 1'b1, 1'b1, 7'h00, 8'h00, 1'b0, 1'b0, 8'h00);

        step(1);
        apply_reset();

        // Table: refresh count and error must stay 0 throughout.
        for (int i = 0; i < tbl.size(); i++) begin
            n_RAS = tbl[i].ras; n_CAS = tbl[i].cas; n_WE = tbl[i].we;
            A = tbl[i].a; DI = tbl[i].di;
            step(1);
            check($sformatf("vec%0d_en", i), {31'd0, DO_EN}, {31'd0, tbl[i].en});
            check($sformatf("vec%0d_err", i), {31'd0, ERR}, 32'd0);
            check($sformatf("vec%0d_ref", i), {24'd0, REFRESH_CNT}, 32'd0);
            if (tbl[i].chk) begin
                check($sformatf("vec%0d_do", i), {24'd0, DO}, {24'd0, tbl[i].dov});
            end
        end

        // Short CAS: one sampled low cycle never produces DO_EN.
        start_ras(7'h12);
        n_CAS = 1'b0; n_WE = 1'b1; A = 7'h34;
        step(1);
        n_CAS = 1'b1;
        seen_en = 1'b0;
        for (int k = 0; k < 6; k++) begin
            step(1);
            seen_en = seen_en | DO_EN;
        end
        check("short_cas_no_en", {31'd0, seen_en}, 32'd0);
        check("short_cas_err", {31'd0, ERR}, 32'd0);
        do_read("after_short", 7'h34, 8'hA5);
        end_ras();

        // Refresh: 300 RAS-only cycles wrap the 8-bit count to 44.
        seen_en = 1'b0;
        for (int k = 0; k < 300; k++) begin
            n_RAS = 1'b0; A = 7'(k);
            step(2);
            seen_en = seen_en | DO_EN;
            n_RAS = 1'b1;
            step(2);
            seen_en = seen_en | DO_EN;
        end
        check("refresh_cnt", {24'd0, REFRESH_CNT}, 32'd44);
        check("refresh_no_en", {31'd0, seen_en}, 32'd0);
        check("refresh_err", {31'd0, ERR}, 32'd0);

        // CAS fall with RAS high.
        n_CAS = 1'b0;
        step(2);
        check("cbr_err", {31'd0, ERR}, 32'd1);
        check("cbr_no_refresh", {24'd0, REFRESH_CNT}, 32'd44);
        n_CAS = 1'b1;
        step(2);

        // RAS rise while CAS low during a read.
        apply_reset();
        start_ras(7'h12);
        n_CAS = 1'b0; n_WE = 1'b1; A = 7'h34;
        step(3);
        check("abort_pre_en", {31'd0, DO_EN}, 32'd1);
        check("abort_pre_do", {24'd0, DO}, 32'hA5);
        n_RAS = 1'b1;
        step(1);
        check("abort_pre_err", {31'd0, ERR}, 32'd0);
        step(1);
        check("abort_err", {31'd0, ERR}, 32'd1);
        check("abort_en", {31'd0, DO_EN}, 32'd0);
        n_CAS = 1'b1;
        step(2);

        // RAS and CAS falling together.
        apply_reset();
        n_RAS = 1'b0; n_CAS = 1'b0; n_WE = 1'b1; A = 7'h12;
        step(2);
        check("same_fall_err", {31'd0, ERR}, 32'd1);
        seen_en = 1'b0;
        for (int k = 0; k < 4; k++) begin
            step(1);
            seen_en = seen_en | DO_EN;
        end
        check("same_fall_no_access", {31'd0, seen_en}, 32'd0);
        end_ras();
        check("same_fall_no_refresh", {24'd0, REFRESH_CNT}, 32'd0);

        // Give the counter a nonzero value before resetting mid-read.
        for (int k = 0; k < 3; k++) begin
            start_ras(7'h01);
            end_ras();
        end
        check("pre_reset_ref", {24'd0, REFRESH_CNT}, 32'd3);

        // Reset asserted while DO_EN is high.
        start_ras(7'h12);
        n_CAS = 1'b0; n_WE = 1'b1; A = 7'h34;
        step(3);
        check("midread_en", {31'd0, DO_EN}, 32'd1);
        #2;
        n_RES = 1'b0;
        #1;
        check("midrst_do", {24'd0, DO}, 32'd0);
        check("midrst_en", {31'd0, DO_EN}, 32'd0);
        check("midrst_ref", {24'd0, REFRESH_CNT}, 32'd0);
        check("midrst_err", {31'd0, ERR}, 32'd0);
        step(1);
        n_RAS = 1'b1; n_CAS = 1'b1;
        step(1);
        n_RES = 1'b1;
        step(1);

        // Memory survives reset.
        start_ras(7'h05);
        do_read("keep_51", 7'h01, 8'h22);
        end_ras();
        start_ras(7'h12);
        do_read("keep_1234", 7'h34, 8'hA5);
        end_ras();
        check("final_err", {31'd0, ERR}, 32'd0);
        check("final_ref", {24'd0, REFRESH_CNT}, 32'd0);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
